// File: rtl/tensor_core_scheduler_if.sv
// Requester-side bundle of the tensor core scheduler.
// Both requesters share these vectors; bit i belongs to requester i.
interface tensor_core_scheduler_if #(
    parameter int OP_WIDTH = 2
);
    logic [1:0]               req_in;
    logic [1:0][OP_WIDTH-1:0] op_in;
    logic [1:0]               load_in;
    logic [1:0]               start_in;
    logic [1:0]               grant_out;
    logic [1:0]               done_out;

    modport master (
        output req_in, op_in, load_in, start_in,
        input  grant_out, done_out
    );

    modport slave (
        input  req_in, op_in, load_in, start_in,
        output grant_out, done_out
    );
endinterface

// File: rtl/tensor_core_scheduler.sv
// Round-robin arbiter and run sequencer in front of small_tensor_core:
// gates operand loads, issues the start pulse and tracks the result element index.
module tensor_core_scheduler #(
    parameter int ELEMENTS = 9,
    parameter int OP_WIDTH = 2
) (
    input  logic                tensor_core_clock,
    input  logic                reset_in,
    tensor_core_scheduler_if.slave req_bus,
    output logic                busy_out,
    output logic                tensor_core_register_file_write_enable,
    output logic                should_start_tensor_core,
    output logic [OP_WIDTH-1:0] operation_select,
    output logic                result_valid_out,
    output logic [1:0]          result_row_out,
    output logic [1:0]          result_col_out
);
    localparam int IDX_W = ($clog2(ELEMENTS) < 2) ? 2 : $clog2(ELEMENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENTS - 1);

    typedef enum logic [1:0] {IDLE, GRANTED, RUN} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          grant_reg, grant_next;
    logic                last_reg, last_next;
    logic [OP_WIDTH-1:0] op_reg, op_next;
    logic                start_reg, start_next;
    logic                busy_reg, busy_next;
    logic                valid_reg, valid_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [1:0]          done_reg, done_next;
    logic [1:0]          row_reg, row_next;
    logic [1:0]          col_reg, col_next;
    logic [1:0]          load_gated;
    logic                g;

    // Only the granted requester's load strobe can reach the core.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_load_gate
            assign load_gated[gi] = grant_reg[gi] & req_bus.load_in[gi];
        end
    endgenerate

    assign g = grant_reg[1];

    always_ff @(posedge tensor_core_clock) begin
        if (reset_in) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= 1'b1;
            op_reg    <= '0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            done_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            op_reg    <= op_next;
            start_reg <= start_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        op_next    = op_reg;
        start_next = 1'b0;
        busy_next  = busy_reg;
        valid_next = valid_reg;
        idx_next   = idx_reg;
        done_next  = '0;

        case (state_reg)
            IDLE: begin
                if (|req_bus.req_in) begin
                    state_next = GRANTED;
                    if (req_bus.req_in == 2'b11)
                        grant_next = last_reg ? 2'b01 : 2'b10;
                    else
                        grant_next = req_bus.req_in;
                end
            end
            GRANTED: begin
                if (!req_bus.req_in[g]) begin
                    grant_next = '0;
                    last_next  = g;
                    state_next = IDLE;
                end else if (req_bus.start_in[g] && !req_bus.load_in[g]) begin
                    op_next    = req_bus.op_in[g];
                    start_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // First RUN cycle is the start-pulse cycle; the core's counter reads 0 after it.
                if (!valid_reg) begin
                    valid_next = 1'b1;
                    idx_next   = '0;
                end else if (idx_reg == LAST_IDX) begin
                    valid_next = 1'b0;
                    idx_next   = '0;
                    grant_next = '0;
                    busy_next  = 1'b0;
                    last_next  = g;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (valid_next && idx_next == LAST_IDX)
            done_next = grant_reg;
    end

    assign row_next = 2'(idx_next / IDX_W'(3));
    assign col_next = 2'(idx_next % IDX_W'(3));

    assign tensor_core_register_file_write_enable = (state_reg == GRANTED) && (|load_gated);
    assign req_bus.grant_out        = grant_reg;
    assign req_bus.done_out         = done_reg;
    assign busy_out                 = busy_reg;
    assign should_start_tensor_core = start_reg;
    assign operation_select         = op_reg;
    assign result_valid_out         = valid_reg;
    assign result_row_out           = row_reg;
    assign result_col_out           = col_reg;
endmodule
